// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer.
//   - ALU operation encodings
//   - sequencer state enum
//   - default ALU datapath width
package alu_pkg;

    localparam int HALF_W_DEF = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIX  = 3'd3,
        RESP = 3'd4
    } seq_state_e;

    // add/sub propagate a carry/borrow between halves; and/xor do not
    function automatic logic is_arith(input logic [1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_issue_if.sv
// Request/response channels between execute-stage control and the ALU
// issue sequencer.
//   master : requester (drives req_*, rsp_ready)
//   slave  : sequencer (drives req_ready, rsp_*)
interface alu_seq_issue_if #(
    parameter int HALF_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic                  req_wide;
    logic [2*HALF_W-1:0]   req_a;
    logic [2*HALF_W-1:0]   req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*HALF_W-1:0]   rsp_result;
    logic                  rsp_flag;

    modport master (
        output req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flag
    );

    modport slave (
        input  req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flag
    );
endinterface

// File: rtl/alu_seq_issue.sv
// Issuing-side sequencer for a HALF_W-bit combinational ALU. Accepts narrow
// (HALF_W) or wide (2*HALF_W) requests, runs the ALU for one to three passes
// and returns the assembled result with carry/borrow flag.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : request/response handshake channels
//   alu_operation/a/b : drive to ALU
//   alu_out/alu_flag  : result from ALU
//   done_count        : completed responses, wrapping
//
// state | meaning
// IDLE  | ready for a request, ALU ports parked at 0
// LO    | low half on the ALU
// HI    | high half on the ALU (wide only)
// FIX   | high result +/-1 to absorb the low-half carry/borrow
// RESP  | response held until rsp_ready
module alu_seq_issue
    import alu_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_seq_issue_if.slave     bus,
    output logic [1:0]         alu_operation,
    output logic [HALF_W-1:0]  alu_a,
    output logic [HALF_W-1:0]  alu_b,
    input  logic [HALF_W-1:0]  alu_out,
    input  logic               alu_flag,
    output logic [CNT_W-1:0]   done_count
);

    seq_state_e            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic                  wide_q, wide_d;
    logic [2*HALF_W-1:0]   a_q, a_d;
    logic [2*HALF_W-1:0]   b_q, b_d;
    logic [HALF_W-1:0]     res_lo_q, res_lo_d;
    logic [HALF_W-1:0]     res_hi_q, res_hi_d;
    logic                  c0_q, c0_d;
    logic                  flag_q, flag_d;
    logic [CNT_W-1:0]      done_count_q, done_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= ALU_ADD;
            wide_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_lo_q     <= '0;
            res_hi_q     <= '0;
            c0_q         <= 1'b0;
            flag_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wide_q       <= wide_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_lo_q     <= res_lo_d;
            res_hi_q     <= res_hi_d;
            c0_q         <= c0_d;
            flag_q       <= flag_d;
            done_count_q <= done_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wide_d        = wide_q;
        a_d           = a_q;
        b_d           = b_q;
        res_lo_d      = res_lo_q;
        res_hi_d      = res_hi_q;
        c0_d          = c0_q;
        flag_d        = flag_q;
        done_count_d  = done_count_q;
        alu_operation = ALU_ADD;
        alu_a         = '0;
        alu_b         = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    wide_d   = bus.req_wide;
                    a_d      = bus.req_a;
                    b_d      = bus.req_b;
                    // narrow responses report a zero upper half
                    res_hi_d = '0;
                    state_d  = LO;
                end
            end
            LO: begin
                alu_operation = op_q;
                alu_a         = a_q[HALF_W-1:0];
                alu_b         = b_q[HALF_W-1:0];
                res_lo_d      = alu_out;
                c0_d          = alu_flag;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    flag_d  = is_arith(op_q) & alu_flag;
                    state_d = RESP;
                end
            end
            HI: begin
                alu_operation = op_q;
                alu_a         = a_q[2*HALF_W-1:HALF_W];
                alu_b         = b_q[2*HALF_W-1:HALF_W];
                res_hi_d      = alu_out;
                flag_d        = is_arith(op_q) & alu_flag;
                // low-half carry/borrow is folded in by a separate +/-1 pass
                if (is_arith(op_q) && c0_q) begin
                    state_d = FIX;
                end else begin
                    state_d = RESP;
                end
            end
            FIX: begin
                alu_operation = op_q;
                alu_a         = res_hi_q;
                alu_b         = HALF_W'(1);
                res_hi_d      = alu_out;
                flag_d        = flag_q | alu_flag;
                state_d       = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ready is masked by reset so nothing is offered while rst_n is low
    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_result = {res_hi_q, res_lo_q};
    assign bus.rsp_flag   = flag_q;
    assign done_count     = done_count_q;

endmodule

// File: tb/tb_alu_seq_issue.sv
module tb_alu_seq_issue;

    localparam int HW = 64;
    localparam int CW = 16;

    logic            clk;
    logic            rst_n;
    logic [1:0]      alu_operation;
    logic [HW-1:0]   alu_a;
    logic [HW-1:0]   alu_b;
    logic [HW-1:0]   alu_out;
    logic            alu_flag;
    logic [CW-1:0]   done_count;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_done = '0;

    alu_seq_issue_if #(.HALF_W(HW)) bus ();

    alu_seq_issue #(.HALF_W(HW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_operation (alu_operation),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_out       (alu_out),
        .alu_flag      (alu_flag),
        .done_count    (done_count)
    );

    // combinational ALU the sequencer is attached to
    always_comb begin
        logic [HW:0] s;
        s        = '0;
        alu_out  = '0;
        alu_flag = 1'b0;
        case (alu_operation)
            2'b00: begin
                s        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out  = s[HW-1:0];
                alu_flag = s[HW];
            end
            2'b01: begin
                alu_out  = alu_a - alu_b;
                alu_flag = (alu_a < alu_b);
            end
            2'b10: alu_out = alu_a & alu_b;
            default: alu_out = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: full-width arithmetic on the request, latency from pass count
    task automatic run_req(input logic [1:0] op, input logic wide,
                           input logic [127:0] a, input logic [127:0] b,
                           input int hold, input string tag);
        logic [128:0] full;
        logic [64:0]  lsum;
        logic [127:0] exp_res;
        logic         exp_flag;
        logic         c0;
        int           exp_lat;
        int           lat;
        int           n;
        logic [127:0] held;

        if (!wide) begin
            full = {65'b0, a[63:0]} + {65'b0, b[63:0]};
            case (op)
                2'b00: begin exp_res = {64'b0, full[63:0]}; exp_flag = full[64]; end
                2'b01: begin exp_res = {64'b0, a[63:0] - b[63:0]}; exp_flag = (a[63:0] < b[63:0]); end
                2'b10: begin exp_res = {64'b0, a[63:0] & b[63:0]}; exp_flag = 1'b0; end
                default: begin exp_res = {64'b0, a[63:0] ^ b[63:0]}; exp_flag = 1'b0; end
            endcase
            exp_lat = 2;
        end else begin
            full = {1'b0, a} + {1'b0, b};
            lsum = {1'b0, a[63:0]} + {1'b0, b[63:0]};
            case (op)
                2'b00: begin exp_res = full[127:0]; exp_flag = full[128]; c0 = lsum[64]; end
                2'b01: begin exp_res = a - b; exp_flag = (a < b); c0 = (a[63:0] < b[63:0]); end
                2'b10: begin exp_res = a & b; exp_flag = 1'b0; c0 = 1'b0; end
                default: begin exp_res = a ^ b; exp_flag = 1'b0; c0 = 1'b0; end
            endcase
            exp_lat = c0 ? 4 : 3;
        end

        n = 0;
        while (!bus.req_ready && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 128'(bus.req_ready), 128'(1));

        bus.req_op    = op;
        bus.req_wide  = wide;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        // scramble the request lines so results must come from latched copies
        bus.req_op    = 2'($urandom());
        bus.req_wide  = 1'($urandom());
        bus.req_a     = rnd128();
        bus.req_b     = rnd128();

        lat = 1;
        while (!bus.rsp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_res"}, bus.rsp_result, exp_res);
        chk({tag, "_flag"}, 128'(bus.rsp_flag), 128'(exp_flag));

        held = bus.rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 128'(bus.rsp_valid), 128'(1));
            chk({tag, "_hold_res"}, bus.rsp_result, held);
            chk({tag, "_hold_ready"}, 128'(bus.req_ready), 128'(0));
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        exp_done = exp_done + CW'(1);
        chk({tag, "_done"}, 128'(done_count), 128'(exp_done));
        chk({tag, "_valid_drop"}, 128'(bus.rsp_valid), 128'(0));
        chk({tag, "_ready_back"}, 128'(bus.req_ready), 128'(1));
    endtask

    initial begin
        logic [1:0]   op;
        logic         wide;
        logic [127:0] a;
        logic [127:0] b;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_wide  = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_result", bus.rsp_result, 128'(0));
        chk("rst_rsp_flag", 128'(bus.rsp_flag), 128'(0));
        chk("rst_done", 128'(done_count), 128'(0));
        chk("rst_alu", {alu_a, alu_b}, 128'(0));
        chk("rst_alu_op", 128'(alu_operation), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 128'(bus.req_ready), 128'(1));

        run_req(2'b00, 1'b0, 128'd5, 128'd7, 0, "n_add");
        run_req(2'b00, 1'b1, 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFF, 128'd1, 0, "w_add_fix");
        run_req(2'b00, 1'b1, {128{1'b1}}, 128'd1, 0, "w_add_wrap");
        run_req(2'b01, 1'b1, 128'd0, 128'd1, 0, "w_sub_borrow");
        run_req(2'b11, 1'b0, 128'hF0F0, 128'h0FF0, 5, "n_xor_hold");
        run_req(2'b10, 1'b1, rnd128(), rnd128(), 1, "w_and");
        run_req(2'b00, 1'b0, {64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF}, {64'hBEEF, 64'd3}, 0, "n_add_carry_upper_ignored");

        for (int k = 0; k < 40; k++) begin
            op   = 2'($urandom());
            wide = 1'($urandom());
            a    = rnd128();
            b    = rnd128();
            if ($urandom_range(0, 3) == 0) a[63:0] = '1;
            if ($urandom_range(0, 3) == 0) a[127:64] = '1;
            if ($urandom_range(0, 3) == 0) b[127:64] = '0;
            run_req(op, wide, a, b, int'($urandom_range(0, 2)), "rand");
        end

        // reset while a wide add is in its high pass
        bus.req_op    = 2'b00;
        bus.req_wide  = 1'b1;
        bus.req_a     = {128{1'b1}};
        bus.req_b     = 128'd1;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_hi_drive", 128'(alu_a), 128'({64{1'b1}}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(bus.rsp_valid), 128'(0));
        chk("mid_rst_alu", {alu_a, alu_b}, 128'(0));
        chk("mid_rst_alu_op", 128'(alu_operation), 128'(0));
        chk("mid_rst_ready", 128'(bus.req_ready), 128'(0));
        chk("mid_rst_done", 128'(done_count), 128'(0));
        #2;
        rst_n = 1'b1;
        exp_done = '0;
        #1;
        chk("rel_ready", 128'(bus.req_ready), 128'(1));
        repeat (4) begin
            @(posedge clk); #1;
            chk("rel_no_rsp", 128'(bus.rsp_valid), 128'(0));
        end
        chk("rel_done", 128'(done_count), 128'(0));

        run_req(2'b01, 1'b0, 128'd3, 128'd9, 0, "post_rst_sub");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
